hub75_frame_loader: RTL and testbench
=====================================

Name: hub75_frame_loader

Overview:
Parametrised successor to the HUB75 memory loader. It accepts a pixel stream (RGB888-style, one pixel per beat), transposes each panel row into per-bit colour planes, and stores them in a double-buffered (ping-pong) frame store. Width, depth and scan count are parametric. A valid/ready read port delivers upper-half and lower-half planes to the panel driver. Bank swaps happen only at frame boundaries, so the display never tears.

Parameters:
DATA_WIDTH, 32, input beat width; must be >= 3*COLOR_DEPTH.
PANEL_W, 64, pixels per row; also the width of each plane output word.
SCAN_ROWS, 32, rows per half-panel; a frame is 2*SCAN_ROWS rows.
COLOR_DEPTH, 8, bits per colour channel (bit-planes per row).
ADDR_WIDTH, 8, read address width; must equal clog2(SCAN_ROWS*COLOR_DEPTH).

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
wr_restart  in  1  synchronous write-pointer reset; discards any partial frame
s_axi_valid  in  1  input pixel valid
s_axi_ready  out  1  input pixel ready
s_axi_data  in  DATA_WIDTH  pixel: R=[COLOR_DEPTH-1:0], G=[2*COLOR_DEPTH-1:COLOR_DEPTH], B=[3*COLOR_DEPTH-1:2*COLOR_DEPTH]
m_axi_valid  out  1  plane word valid
m_axi_ready  in  1  driver accepts plane word
o_addr  out  ADDR_WIDTH  plane address = row_local*COLOR_DEPTH + bit
o_frame_start  out  1  high with the addr-0 word
o_frame_bank  out  1  bank currently displayed
bram_red_0/green_0/blue_0  out  PANEL_W  upper-half planes (rows 0..SCAN_ROWS-1)
bram_red_1/green_1/blue_1  out  PANEL_W  lower-half planes (rows SCAN_ROWS..2*SCAN_ROWS-1)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs drive 0. Write and read pointers clear. Both banks are marked empty.
  - o_frame_bank=0; no frame is displayable.
  - s_axi_ready=1 from the first cycle after rst_n returns high.
- Write FSM: FILL -> FLUSH -> FILL, or FILL -> FLUSH -> WAIT_SWAP.
  - FILL: s_axi_ready=1. Each s_axi_valid&&s_axi_ready beat shifts the pixel's per-bit channel values into 3*COLOR_DEPTH PANEL_W-bit shift registers. The pixel arriving at column c lands in bit c.
  - After column PANEL_W-1 is accepted, go to FLUSH.
  - FLUSH: exactly COLOR_DEPTH cycles with s_axi_ready=0. Cycle b writes plane b of R/G/B into the back bank, half (row>=SCAN_ROWS), at address (row mod SCAN_ROWS)*COLOR_DEPTH+b.
  - After FLUSH, go back to FILL, unless that was row 2*SCAN_ROWS-1; then go to WAIT_SWAP.
  - WAIT_SWAP: s_axi_ready=0 and swap_pending=1.
- Swap rules:
  - If nothing has been displayed since reset, the swap occurs on the cycle after WAIT_SWAP is entered.
  - Otherwise the swap occurs on the read handshake of address SCAN_ROWS*COLOR_DEPTH-1 while swap_pending=1.
  - If swap_pending sets in the same cycle as that wrap handshake, the swap waits for the next wrap.
  - On swap: o_frame_bank toggles, row pointer -> 0, FSM -> FILL.
- Read port:
  - m_axi_valid=0 until the first swap. After that it stays 1 for as long as a frame is displayable; the last frame repeats indefinitely.
  - Once m_axi_valid is high, o_addr and the plane outputs hold stable until m_axi_valid&&m_axi_ready.
  - The address advances by 1 per handshake and wraps from SCAN_ROWS*COLOR_DEPTH-1 to 0.
  - Sustained throughput is 1 word/cycle with m_axi_ready held high. This requires a prefetch/skid pipeline over the 1-cycle memory read.
  - First m_axi_valid appears within 3 cycles of the first swap.
  - o_frame_start=1 exactly when o_addr=0 and m_axi_valid=1.
  - Words presented after a wrap handshake come from the new bank.
- wr_restart:
  - In any write state: column and row pointers -> 0, FSM -> FILL, swap_pending clears.
  - The front bank and the read side are unaffected.
  - Has priority over a same-cycle input beat, which is dropped.
- Reset mid-operation: rst_n=0 in any cycle clears everything. m_axi_valid is 0 on the following cycle; a full frame must be reloaded before display resumes.

Test Plan:
- Reset then idle -> all outputs 0; s_axi_ready=1 on the first cycle after release; m_axi_valid=0 for 100 cycles.
- One frame (defaults): all zeros except row0 col0 R=0x01, and row32 col63 B=0x80 -> addr0: bram_red_0=64'h1, all other colours 0. Addr7: bram_blue_1=1<<63. All 256 addresses otherwise 0. o_frame_start only at addr0.
- Input back-pressure: random s_axi_valid gaps -> s_axi_ready low for exactly 8 cycles after each row's 64th pixel. Scoreboard across 2 frames shows no lost or duplicated pixel.
- Double buffer: display frame A with m_axi_ready pulsed 1-in-9, then load frame B -> s_axi_ready stays 0 after B completes. After the wrap handshake at addr 255: o_frame_bank toggles, addr0 shows B data, s_axi_ready returns to 1.
- wr_restart after 10 pixels of a row -> the next 64*64 pixels form a complete frame starting at row0 col0. Displayed data stays unchanged until that frame swaps in.
- rst_n pulsed low for 1 cycle mid-readout (addr 100) -> m_axi_valid=0 the next cycle and stays 0 until a full frame is reloaded; o_frame_bank=0.

Source files
------------

// File: rtl/hub75_frame_loader.sv
// HUB75 frame loader: transposes a pixel stream into per-bit colour planes held
// in a ping-pong frame store, and serves upper/lower half planes over valid/ready.
module hub75_frame_loader #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PANEL_W     = 64,
  parameter int unsigned SCAN_ROWS   = 32,
  parameter int unsigned COLOR_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_restart,
  input  logic                  s_axi_valid,
  output logic                  s_axi_ready,
  input  logic [DATA_WIDTH-1:0] s_axi_data,
  output logic                  m_axi_valid,
  input  logic                  m_axi_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_frame_start,
  output logic                  o_frame_bank,
  output logic [PANEL_W-1:0]    bram_red_0,
  output logic [PANEL_W-1:0]    bram_green_0,
  output logic [PANEL_W-1:0]    bram_blue_0,
  output logic [PANEL_W-1:0]    bram_red_1,
  output logic [PANEL_W-1:0]    bram_green_1,
  output logic [PANEL_W-1:0]    bram_blue_1
);

  localparam int unsigned ROWS      = 2 * SCAN_ROWS;
  localparam int unsigned CW        = (PANEL_W > 1) ? $clog2(PANEL_W) : 1;
  localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned BW        = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
  localparam int unsigned DEPTH     = SCAN_ROWS * COLOR_DEPTH;
  localparam int unsigned MEM_WORDS = 2 ** (ADDR_WIDTH + 1);

  typedef enum logic [1:0] {FILL, FLUSH, WAIT_SWAP} wstate_e;

  wstate_e               wstate_q;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic [BW-1:0]         bit_q;
  logic                  ready_q;
  logic                  bank_q, bank_d;
  logic                  shown_q, shown_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  fs_q;
  logic [PANEL_W-1:0]    rd_r0_q, rd_g0_q, rd_b0_q, rd_r1_q, rd_g1_q, rd_b1_q;

  logic [PANEL_W-1:0] sh_r_q [COLOR_DEPTH];
  logic [PANEL_W-1:0] sh_g_q [COLOR_DEPTH];
  logic [PANEL_W-1:0] sh_b_q [COLOR_DEPTH];

  logic [PANEL_W-1:0] mem_r0 [MEM_WORDS];
  logic [PANEL_W-1:0] mem_g0 [MEM_WORDS];
  logic [PANEL_W-1:0] mem_b0 [MEM_WORDS];
  logic [PANEL_W-1:0] mem_r1 [MEM_WORDS];
  logic [PANEL_W-1:0] mem_g1 [MEM_WORDS];
  logic [PANEL_W-1:0] mem_b1 [MEM_WORDS];

  logic                  accept, hs, wrap, swap, hi_half, we;
  logic [RW-1:0]         row_loc;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH:0]   raddr;

  if (DATA_WIDTH > 3 * COLOR_DEPTH) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^s_axi_data[DATA_WIDTH-1:3*COLOR_DEPTH];
  end

  always_comb begin
    accept  = s_axi_valid && ready_q && !wr_restart;
    hs      = shown_q && m_axi_ready;
    wrap    = hs && (addr_q == ADDR_WIDTH'(DEPTH - 1));
    // swap_pending is the WAIT_SWAP state itself, so a wrap on the entry edge cannot swap
    swap    = (wstate_q == WAIT_SWAP) && !wr_restart && (!shown_q || wrap);
    bank_d  = bank_q ^ swap;
    shown_d = shown_q | swap;
    addr_d  = addr_q;
    if (!shown_q) addr_d = '0;
    else if (hs)  addr_d = wrap ? '0 : addr_q + 1'b1;
    raddr   = {bank_d, addr_d};
    hi_half = (row_q >= RW'(SCAN_ROWS));
    row_loc = hi_half ? row_q - RW'(SCAN_ROWS) : row_q;
    waddr   = ADDR_WIDTH'(row_loc) * ADDR_WIDTH'(COLOR_DEPTH) + ADDR_WIDTH'(bit_q);
    we      = rst_n && !wr_restart && (wstate_q == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate_q <= FILL;
      col_q    <= '0;
      row_q    <= '0;
      bit_q    <= '0;
      ready_q  <= 1'b0;
      bank_q   <= 1'b0;
      shown_q  <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      shown_q <= shown_d;
      if (wr_restart) begin
        wstate_q <= FILL;
        col_q    <= '0;
        row_q    <= '0;
        bit_q    <= '0;
        ready_q  <= 1'b1;
      end else begin
        case (wstate_q)
          FILL: begin
            ready_q <= 1'b1;
            if (accept) begin
              if (col_q == CW'(PANEL_W - 1)) begin
                col_q    <= '0;
                wstate_q <= FLUSH;
                ready_q  <= 1'b0;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
          FLUSH: begin
            if (bit_q == BW'(COLOR_DEPTH - 1)) begin
              bit_q <= '0;
              if (row_q == RW'(ROWS - 1)) begin
                wstate_q <= WAIT_SWAP;
              end else begin
                row_q    <= row_q + 1'b1;
                wstate_q <= FILL;
                ready_q  <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
          WAIT_SWAP: begin
            if (swap) begin
              row_q    <= '0;
              wstate_q <= FILL;
              ready_q  <= 1'b1;
            end
          end
          default: wstate_q <= FILL;
        endcase
      end
    end
  end

  // Column c ends up in bit c: new pixels enter at the MSB and shift down.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < COLOR_DEPTH; i++) begin
        sh_r_q[i] <= {s_axi_data[i],                 sh_r_q[i][PANEL_W-1:1]};
        sh_g_q[i] <= {s_axi_data[COLOR_DEPTH + i],   sh_g_q[i][PANEL_W-1:1]};
        sh_b_q[i] <= {s_axi_data[2*COLOR_DEPTH + i], sh_b_q[i][PANEL_W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      if (hi_half) begin
        mem_r1[{~bank_q, waddr}] <= sh_r_q[bit_q];
        mem_g1[{~bank_q, waddr}] <= sh_g_q[bit_q];
        mem_b1[{~bank_q, waddr}] <= sh_b_q[bit_q];
      end else begin
        mem_r0[{~bank_q, waddr}] <= sh_r_q[bit_q];
        mem_g0[{~bank_q, waddr}] <= sh_g_q[bit_q];
        mem_b0[{~bank_q, waddr}] <= sh_b_q[bit_q];
      end
    end
  end

  // Read address is the next presented address, so the registered read lands
  // exactly when that word is due and holds while the driver stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      fs_q    <= 1'b0;
      rd_r0_q <= '0;
      rd_g0_q <= '0;
      rd_b0_q <= '0;
      rd_r1_q <= '0;
      rd_g1_q <= '0;
      rd_b1_q <= '0;
    end else begin
      addr_q  <= addr_d;
      fs_q    <= shown_d && (addr_d == '0);
      rd_r0_q <= shown_d ? mem_r0[raddr] : '0;
      rd_g0_q <= shown_d ? mem_g0[raddr] : '0;
      rd_b0_q <= shown_d ? mem_b0[raddr] : '0;
      rd_r1_q <= shown_d ? mem_r1[raddr] : '0;
      rd_g1_q <= shown_d ? mem_g1[raddr] : '0;
      rd_b1_q <= shown_d ? mem_b1[raddr] : '0;
    end
  end

  assign s_axi_ready   = ready_q;
  assign m_axi_valid   = shown_q;
  assign o_addr        = addr_q;
  assign o_frame_start = fs_q;
  assign o_frame_bank  = bank_q;
  assign bram_red_0    = rd_r0_q;
  assign bram_green_0  = rd_g0_q;
  assign bram_blue_0   = rd_b0_q;
  assign bram_red_1    = rd_r1_q;
  assign bram_green_1  = rd_g1_q;
  assign bram_blue_1   = rd_b1_q;

endmodule

// File: tb/tb_hub75_frame_loader.sv
// Bench for hub75_frame_loader: frames are held as pixel images, plane words are
// predicted from them and checked on every read handshake.
`timescale 1ns/1ps
module tb_hub75_frame_loader;
  localparam int DW = 32, PW = 64, SR = 32, CD = 8, AW = 8;
  localparam int ROWS = 2 * SR, DEPTH = SR * CD;

  logic clk = 1'b0, rst_n = 1'b0, wr_restart = 1'b0;
  logic s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0, fs, bank;
  logic [DW-1:0] s_data = '0;
  logic [AW-1:0] addr;
  logic [PW-1:0] r0, g0, b0, r1, g1, b1;
  logic [6*PW-1:0] planes;
  assign planes = {b1, g1, r1, b0, g0, r0};

  always #5 clk = ~clk;

  hub75_frame_loader #(.DATA_WIDTH(DW), .PANEL_W(PW), .SCAN_ROWS(SR),
                       .COLOR_DEPTH(CD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_restart(wr_restart),
    .s_axi_valid(s_valid), .s_axi_ready(s_ready), .s_axi_data(s_data),
    .m_axi_valid(m_valid), .m_axi_ready(m_ready), .o_addr(addr),
    .o_frame_start(fs), .o_frame_bank(bank),
    .bram_red_0(r0), .bram_green_0(g0), .bram_blue_0(b0),
    .bram_red_1(r1), .bram_green_1(g1), .bram_blue_1(b1));

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            fs;
    logic [6*PW-1:0] w;
  } exp_t;

  typedef struct {
    int          row;
    int          col;
    logic [23:0] p;
    int          addr;
    int          sel;
    logic [63:0] w;
  } vec_t;

  int tests = 0, fails = 0;
  logic [23:0]     pix [3][ROWS][PW];
  logic [6*PW-1:0] cap [DEPTH];
  exp_t            sb [$];
  vec_t            vt [6];
  logic            b_pend = 1'b0;

  // reader state for the double-buffer phase
  int              rd_cyc, rd_exp_a, rd_viol;
  bit              rd_hv, rd_done, rd_sw;
  logic [399:0]    rd_held;

  task automatic check(input string nm, input logic [399:0] act, input logic [399:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6*PW-1:0] model_all(input int f, input int a);
    logic [6*PW-1:0] w;
    w = '0;
    for (int sel = 0; sel < 6; sel++) begin
      for (int c = 0; c < PW; c++) begin
        w[sel*PW + c] = pix[f][(sel/3)*SR + a/CD][c][(sel%3)*CD + a%CD];
      end
    end
    return w;
  endfunction

  task automatic push_frame(input int f);
    exp_t e;
    for (int a = 0; a < DEPTH; a++) begin
      e.addr = AW'(a);
      e.fs   = (a == 0);
      e.w    = model_all(f, a);
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [23:0] p);
    int w = 0;
    s_valid = 1'b1;
    s_data  = {8'($urandom), p};
    while (!s_ready && w < 50) begin
      tick;
      w++;
    end
    if (w == 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 50 cycles");
    end
    tick;
    s_valid = 1'b0;
  endtask

  task automatic load_frame(input int f, input bit gaps, input bit bp);
    int lo;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < PW; c++) begin
        if (gaps && $urandom_range(2) == 0) repeat ($urandom_range(3, 1)) tick;
        send(pix[f][r][c]);
        if (bp && c == PW - 1 && r != ROWS - 1) begin
          lo = 0;
          while (!s_ready && lo < 20) begin
            lo++;
            tick;
          end
          check("bp_low_cycles", lo, 8);
        end
      end
    end
  endtask

  task automatic read_sb(input int n, input bit cap_en);
    int got = 0, stall = 0, cyc = 0;
    exp_t e;
    m_ready = 1'b1;
    while (got < n && cyc < n + 20) begin
      if (m_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got word at addr %0d expected none", addr);
        end else begin
          e = sb.pop_front();
          check("rd_addr", addr, e.addr);
          check("rd_fs", fs, e.fs);
          check("rd_planes", planes, e.w);
          if (cap_en) cap[addr] = planes;
        end
        got++;
      end else begin
        stall++;
      end
      tick;
      cyc++;
    end
    m_ready = 1'b0;
    check("rd_words", got, n);
    check("rd_stalls", stall, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish before 5ms");
    $fatal(1);
  end

  initial begin
    logic [6*PW-1:0] cw;
    int w, cnt, k;

    vt[0] = '{0,  0,  24'h000001, 0,   0, 64'h1};
    vt[1] = '{32, 63, 24'h800000, 7,   5, 64'h8000_0000_0000_0000};
    vt[2] = '{1,  5,  24'h000400, 10,  1, 64'h20};
    vt[3] = '{63, 10, 24'h000080, 255, 3, 64'h400};
    vt[4] = '{31, 62, 24'h010000, 248, 2, 64'h4000_0000_0000_0000};
    vt[5] = '{40, 33, 24'h001000, 68,  4, 64'h0000_0002_0000_0000};
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < PW; c++)
          pix[f][r][c] = (f == 0) ? 24'h0 : 24'($urandom);
    for (int i = 0; i < 6; i++) pix[0][vt[i].row][vt[i].col] = vt[i].p;

    // reset and idle
    repeat (3) tick;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_addr", addr, 0);
    check("rst_fs", fs, 0);
    check("rst_bank", bank, 0);
    check("rst_planes", planes, 0);
    rst_n = 1'b1;
    tick;
    check("ready_after_rst", s_ready, 1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_valid !== 1'b0 || planes !== '0) cnt++;
      tick;
    end
    check("idle_no_valid", cnt, 0);

    // frame A: sparse table pixels, first swap, full readout
    load_frame(0, 1'b0, 1'b0);
    repeat (7) tick;
    tick;
    check("a_wait_ready", s_ready, 0);
    check("a_wait_valid", m_valid, 0);
    w = 0;
    while (!m_valid && w < 3) begin
      tick;
      w++;
    end
    check("a_first_valid", m_valid, 1);
    check("a_bank", bank, 1);
    check("a_ready_back", s_ready, 1);
    push_frame(0);
    read_sb(DEPTH, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cw = cap[vt[i].addr];
      check("vec_word", cw[vt[i].sel*PW +: PW], vt[i].w);
    end

    // frame B with input gaps while A is read 1-in-9
    rd_cyc = 0; rd_exp_a = 0; rd_viol = 0; rd_hv = 0; rd_done = 0; b_pend = 1'b0;
    fork
      begin
        load_frame(1, 1'b1, 1'b1);
        repeat (7) tick;
        @(posedge clk);
        b_pend = 1'b1;
        #1;
      end
      begin
        while (!rd_done && rd_cyc < 40000) begin
          m_ready = (rd_cyc % 9 == 0);
          if (rd_hv) check("hold_stable", {addr, planes}, rd_held);
          if (b_pend && s_ready) rd_viol++;
          rd_hv   = m_valid && !m_ready;
          rd_held = {addr, planes};
          rd_sw   = 1'b0;
          if (m_valid && m_ready) begin
            check("a_addr", addr, rd_exp_a);
            check("a_planes", planes, model_all(0, rd_exp_a));
            rd_sw    = b_pend && (rd_exp_a == DEPTH - 1);
            rd_exp_a = (rd_exp_a + 1) % DEPTH;
          end
          tick;
          rd_cyc++;
          if (rd_sw) begin
            check("swap_bank", bank, 0);
            check("swap_ready", s_ready, 1);
            check("swap_addr", addr, 0);
            check("swap_fs", fs, 1);
            check("swap_planes", planes, model_all(1, 0));
            rd_done = 1'b1;
          end
        end
        m_ready = 1'b0;
      end
    join
    check("swap_seen", rd_done, 1);
    check("ready_held_low", rd_viol, 0);

    // wr_restart mid-row drops the partial frame and the same-cycle beat
    for (int i = 0; i < 2 * PW + 10; i++) send(24'($urandom));
    s_valid = 1'b1;
    s_data = 32'hDEAD_BEEF;
    wr_restart = 1'b1;
    tick;
    wr_restart = 1'b0;
    s_valid = 1'b0;
    check("restart_ready", s_ready, 1);
    push_frame(1);
    read_sb(DEPTH, 1'b0);
    load_frame(2, 1'b0, 1'b0);
    push_frame(1);
    push_frame(2);
    read_sb(2 * DEPTH, 1'b0);
    check("c_bank", bank, 1);

    // reset mid-readout
    m_ready = 1'b1;
    k = 0;
    while (addr != 8'd100 && k < 300) begin
      tick;
      k++;
    end
    check("reach_addr100", addr, 100);
    m_ready = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_bank", bank, 0);
    check("mid_rst_addr", addr, 0);
    check("mid_rst_planes", planes, 0);
    tick;
    check("mid_rst_ready", s_ready, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_valid !== 1'b0) cnt++;
      tick;
    end
    check("mid_rst_idle", cnt, 0);
    load_frame(0, 1'b0, 1'b0);
    repeat (7) tick;
    tick;
    check("reload_no_valid", m_valid, 0);
    w = 0;
    while (!m_valid && w < 3) begin
      tick;
      w++;
    end
    check("reload_valid", m_valid, 1);
    check("reload_bank", bank, 1);
    push_frame(0);
    read_sb(DEPTH, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
